// File: rtl/seven_seg_pkg.sv
// Shared definitions for the BCD seven-segment display: segment patterns,
// controller states and compile-time sizing helpers.
package seven_seg_pkg;

    // Active-low patterns, bit order g..a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    // ceil(bin_w*log10(2) + 1) digits, never fewer than the display has.
    function automatic int bcd_field_width(input int bin_w, input int num_digits);
        int digits;
        digits = (bin_w * 30103) / 100000 + 2;
        if (digits < num_digits)
            digits = num_digits;
        return 4 * digits;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++)
            p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// One digit: BCD nibble plus blank/dash flags to a 7-segment pattern.
// Blank wins over dash, dash wins over the digit.
module seven_seg_encoder
    import seven_seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    logic [6:0] w_pat;

    always_comb begin
        if (i_blank)
            w_pat = SEG_BLANK;
        else if (i_dash)
            w_pat = SEG_DASH;
        else
            w_pat = digit_pattern(i_digit);
    end

    assign o_seg = (ACTIVE_LOW != 0) ? w_pat : ~w_pat;

endmodule

// File: rtl/seven_seg_bcd_display.sv
// Multi-digit seven-segment driver: handshake-loaded binary value, sequential
// double-dabble to BCD, atomic digit commit, blanking, blink and overflow.
module seven_seg_bcd_display
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    value_valid,
    input  logic [BIN_W-1:0]        value,
    output logic                    ready,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int          BCD_W   = bcd_field_width(BIN_W, NUM_DIGITS);
    localparam int          SR_W    = BCD_W + BIN_W;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam int          BLK_W   = $clog2(BLINK_DIV);
    localparam logic [63:0] LIMIT   = pow10(NUM_DIGITS);
    localparam logic [6:0]  OFF_PAT = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

    state_t                       r_state;
    logic                         r_ready;
    logic                         r_overflow;
    logic                         r_ovf_pend;
    logic [SR_W-1:0]              r_sr;
    logic [CNT_W-1:0]             r_iter;
    logic [NUM_DIGITS-1:0][3:0]   r_digits;
    logic [BLK_W-1:0]             r_blink_cnt;
    logic                         r_blink_on;
    logic [7*NUM_DIGITS-1:0]      r_seg;

    logic [SR_W-1:0]              w_adj;
    logic [NUM_DIGITS-1:0]        w_blank;
    logic                         w_run;
    logic [7*NUM_DIGITS-1:0]      w_seg_all;

    // Shift register layout: {BCD field, binary}; binary bits migrate upward.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_adj = r_sr;
        for (int k = 0; k < BCD_W / 4; k++) begin
            if (r_sr[BIN_W + 4*k +: 4] >= 4'd5)
                w_adj[BIN_W + 4*k +: 4] = r_sr[BIN_W + 4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_sr       <= '0;
            r_iter     <= '0;
            r_digits   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (value_valid && r_ready) begin
                        r_sr       <= SR_W'(value);
                        r_iter     <= '0;
                        r_ovf_pend <= (64'(value) >= LIMIT);
                        r_ready    <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_sr   <= {w_adj[SR_W-2:0], 1'b0};
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == CNT_W'(BIN_W - 1))
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        r_digits[i] <= r_sr[BIN_W + 4*i +: 4];
                    r_overflow <= r_ovf_pend;
                    r_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Walk from the most significant digit down; w_run stays set while all digits so far are zero.
    always_comb begin
        w_run   = 1'b1;
        w_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run      = w_run && (r_digits[i] == 4'd0);
            w_blank[i] = !r_blink_on || ((i != 0) && blank_lz && !r_overflow && w_run);
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        seven_seg_encoder #(
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_enc (
            .i_digit(r_digits[gi]),
            .i_blank(w_blank[gi]),
            .i_dash (r_overflow),
            .o_seg  (w_seg_all[7*gi +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_seg <= {NUM_DIGITS{OFF_PAT}};
        else
            r_seg <= w_seg_all;
    end

    assign ready    = r_ready;
    assign overflow = r_overflow;
    assign seg      = r_seg;

endmodule

// File: tb/tb_seven_seg_bcd_display.sv
// Directed bench for seven_seg_bcd_display: vector table plus hand-written
// sequences for blanking change, busy requests, blink and mid-conversion reset.
module tb_seven_seg_bcd_display;

    localparam int ND = 4;
    localparam int BW = 14;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0011000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic            clk = 1'b0;
    logic            rst;
    logic            value_valid;
    logic [BW-1:0]   value;
    logic            ready;
    logic            blank_lz;
    logic            blink_en;
    logic            overflow;
    logic [7*ND-1:0] seg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [BW-1:0]   value;
        logic            blz;
        logic [7*ND-1:0] exp_seg;
        logic            exp_ovf;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    seven_seg_bcd_display #(
        .NUM_DIGITS(ND),
        .BIN_W     (BW),
        .BLINK_DIV (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_valid(value_valid),
        .value      (value),
        .ready      (ready),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .overflow   (overflow),
        .seg        (seg)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, then presents value for exactly one accept edge.
    task automatic send(input logic [BW-1:0] v);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", ready, 1);
        value       = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic wait_done(output int busy);
        busy = 0;
        while (!ready && busy < 200) begin
            busy++;
            tick();
        end
    endtask

    initial begin
        int busy;
        int drops;
        logic [7*ND-1:0] exp_blink;

        vecs[0] = '{14'd0,     1'b0, {S0, S0, S0, S0}, 1'b0};
        vecs[1] = '{14'd1234,  1'b0, {S1, S2, S3, S4}, 1'b0};
        vecs[2] = '{14'd7,     1'b1, {SB, SB, SB, S7}, 1'b0};
        vecs[3] = '{14'd10000, 1'b0, {SD, SD, SD, SD}, 1'b1};
        vecs[4] = '{14'd9999,  1'b0, {S9, S9, S9, S9}, 1'b0};
        vecs[5] = '{14'd0,     1'b1, {SB, SB, SB, S0}, 1'b0};
        vecs[6] = '{14'd16383, 1'b0, {SD, SD, SD, SD}, 1'b1};
        vecs[7] = '{14'd1005,  1'b1, {S1, S0, S0, S5}, 1'b0};
        vecs[8] = '{14'd40,    1'b1, {SB, SB, S4, S0}, 1'b0};
        vecs[9] = '{14'd42,    1'b0, {S0, S0, S4, S2}, 1'b0};

        rst         = 1'b1;
        value_valid = 1'b0;
        value       = '0;
        blank_lz    = 1'b0;
        blink_en    = 1'b0;
        repeat (3) tick();
        check("reset_seg", seg, {SB, SB, SB, SB});
        check("reset_ready", ready, 1);
        check("reset_ovf", overflow, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            blank_lz = vecs[i].blz;
            send(vecs[i].value);
            wait_done(busy);
            check($sformatf("vec%0d_busy", i), busy, BW + 1);
            tick();
            check($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
        end

        // Leading-zero blanking follows blank_lz on the next seg update.
        blank_lz = 1'b1;
        send(14'd7);
        wait_done(busy);
        tick();
        check("blz_on_seg", seg, {SB, SB, SB, S7});
        blank_lz = 1'b0;
        tick();
        check("blz_off_seg", seg, {S0, S0, S0, S7});

        // Request while busy is dropped; only one conversion occurs.
        send(14'd1234);
        tick();
        tick();
        value       = 14'd55;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        wait_done(busy);
        check("busy_remaining", busy, BW - 2);
        tick();
        check("busy_seg", seg, {S1, S2, S3, S4});
        drops = 0;
        for (int k = 0; k < 25; k++) begin
            if (!ready)
                drops++;
            tick();
        end
        check("busy_no_second_conv", drops, 0);
        check("busy_seg_after", seg, {S1, S2, S3, S4});

        // Blink with a 4-cycle half-period.
        send(14'd42);
        wait_done(busy);
        tick();
        check("blink_pre_seg", seg, {S0, S0, S4, S2});
        blink_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_blink = (((k - 1) / 4) % 2 == 0) ? {S0, S0, S4, S2} : {SB, SB, SB, SB};
            check($sformatf("blink_k%0d", k), seg, exp_blink);
        end
        blink_en = 1'b0;
        tick();
        tick();
        check("blink_off_seg", seg, {S0, S0, S4, S2});

        // Overflow then reset mid-conversion of 999.
        send(14'd12345);
        wait_done(busy);
        tick();
        check("pre_rst_ovf", overflow, 1);
        send(14'd999);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_seg", seg, {SB, SB, SB, SB});
        check("midrst_ready", ready, 1);
        check("midrst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (BW + 6) tick();
        check("midrst_no_commit_seg", seg, {S0, S0, S0, S0});
        check("midrst_ready_after", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
